// File: rtl/wb_pkg.sv
// Shared Wishbone bus widths, timeout read data and arbiter FSM state encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
package wb_pkg;

  localparam int WB_ADR_W = 16;
  localparam int WB_DAT_W = 8;

  // Read data returned to a master whose transfer was forcibly terminated
  localparam logic [WB_DAT_W-1:0] TIMEOUT_DATA = 8'hFF;

  // Arbiter FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_TERM = 2'd2;

endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// Round-robin picker: one-hot grant to the first requester at or after ptr_i, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  logic hit;

  // Search upper segment [ptr..N-1] first, then wrap to [0..ptr-1]
  always_comb begin
    gnt_o = '0;
    hit   = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!hit && req_i[j] && (PW'(j) >= ptr_i)) begin
        gnt_o[j] = 1'b1;
        hit      = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!hit && req_i[j]) begin
        gnt_o[j] = 1'b1;
        hit      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter, N masters onto one slave bus, with a watchdog that force-acks hung transfers.
// Latency: 1 cycle cyc-to-grant; slave signals are muxed combinationally while BUSY.
// Backpressure: losing masters simply wait with cyc held; grant stays with the owner until its cyc falls.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int N_MASTERS      = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_MASTERS-1:0]           m_wb_cyc_i,
  input  logic [N_MASTERS-1:0]           m_wb_stb_i,
  input  logic [N_MASTERS-1:0]           m_wb_we_i,
  input  logic [WB_ADR_W*N_MASTERS-1:0]  m_wb_adr_i,
  input  logic [WB_DAT_W*N_MASTERS-1:0]  m_wb_dat_i,
  output logic [WB_DAT_W-1:0]            m_wb_dat_o,
  output logic [N_MASTERS-1:0]           m_wb_ack_o,
  output logic                           s_wb_cyc_o,
  output logic                           s_wb_stb_o,
  output logic                           s_wb_we_o,
  output logic [WB_ADR_W-1:0]            s_wb_adr_o,
  output logic [WB_DAT_W-1:0]            s_wb_dat_o,
  input  logic [WB_DAT_W-1:0]            s_wb_dat_i,
  input  logic                           s_wb_ack_i,
  output logic [N_MASTERS-1:0]           grant_o,
  output logic [7:0]                     timeout_cnt_o
);

  localparam int PW   = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  // Watchdog value at which one more unanswered stb cycle means expiry
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 2);

  logic [1:0]           state_q, state_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [7:0]           tcnt_q, tcnt_d;

  logic                 g_cyc, g_stb, g_we;
  logic [WB_ADR_W-1:0]  g_adr;
  logic [WB_DAT_W-1:0]  g_dat;
  logic [PW-1:0]        g_idx;
  logic [PW-1:0]        ptr_next;
  logic [N_MASTERS-1:0] pick_gnt;
  logic                 busy, term, expire, timeout_pending;

  rr_pick #(.N(N_MASTERS), .PW(PW)) u_pick (
    .req_i (m_wb_cyc_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt)
  );

  // Select the granted master's bus signals and index from the one-hot grant
  always_comb begin
    g_cyc = 1'b0;
    g_stb = 1'b0;
    g_we  = 1'b0;
    g_adr = '0;
    g_dat = '0;
    g_idx = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (grant_q[k]) begin
        g_cyc = m_wb_cyc_i[k];
        g_stb = m_wb_stb_i[k];
        g_we  = m_wb_we_i[k];
        g_adr = m_wb_adr_i[k*WB_ADR_W +: WB_ADR_W];
        g_dat = m_wb_dat_i[k*WB_DAT_W +: WB_DAT_W];
        g_idx = PW'(k);
      end
    end
  end

  assign busy            = (state_q == ST_BUSY);
  assign term            = (state_q == ST_TERM);
  assign timeout_pending = term;
  assign ptr_next        = (g_idx == PW'(N_MASTERS - 1)) ? '0 : g_idx + 1'b1;
  // A slave ack in the expiry cycle suppresses the forced termination
  assign expire          = busy && g_cyc && g_stb && !s_wb_ack_i && (wd_q == WD_LAST);

  // FSM, grant, rotation pointer, watchdog and timeout counter next-state
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    wd_d    = '0;
    tcnt_d  = tcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|m_wb_cyc_i) begin
          grant_d = pick_gnt;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!g_cyc) begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = ptr_next;
        end else if (expire) begin
          state_d = ST_TERM;
          if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
        end else if (g_stb && !s_wb_ack_i) begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_TERM: begin
        if (g_cyc) begin
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = ptr_next;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      wd_q    <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign s_wb_cyc_o    = busy && g_cyc;
  assign s_wb_stb_o    = busy && g_stb && !timeout_pending;
  assign s_wb_we_o     = busy && g_we;
  assign s_wb_adr_o    = busy ? g_adr : '0;
  assign s_wb_dat_o    = busy ? g_dat : '0;

  assign m_wb_ack_o    = busy ? (grant_q & {N_MASTERS{s_wb_ack_i}}) :
                         term ? grant_q : '0;
  assign m_wb_dat_o    = busy ? s_wb_dat_i :
                         term ? TIMEOUT_DATA : '0;

  assign grant_o       = grant_q;
  assign timeout_cnt_o = tcnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (2 masters, 8-cycle watchdog).
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
// Covers reset, contention, rotation, burst atomicity, timeout, ack/timeout collision, async reset.
module tb_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  m_cyc, m_stb, m_we;
  logic [31:0] m_adr;
  logic [15:0] m_dat;
  logic [7:0]  m_dat_o;
  logic [1:0]  m_ack;
  logic        s_cyc, s_stb, s_we;
  logic [15:0] s_adr;
  logic [7:0]  s_dat_o;
  logic [7:0]  s_dat_i;
  logic        s_ack;
  logic [1:0]  grant;
  logic [7:0]  tcnt;

  int n_cmp = 0;
  int n_bad = 0;

  wb_arbiter #(.N_MASTERS(2), .TIMEOUT_CYCLES(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .m_wb_cyc_i    (m_cyc),
    .m_wb_stb_i    (m_stb),
    .m_wb_we_i     (m_we),
    .m_wb_adr_i    (m_adr),
    .m_wb_dat_i    (m_dat),
    .m_wb_dat_o    (m_dat_o),
    .m_wb_ack_o    (m_ack),
    .s_wb_cyc_o    (s_cyc),
    .s_wb_stb_o    (s_stb),
    .s_wb_we_o     (s_we),
    .s_wb_adr_o    (s_adr),
    .s_wb_dat_o    (s_dat_o),
    .s_wb_dat_i    (s_dat_i),
    .s_wb_ack_i    (s_ack),
    .grant_o       (grant),
    .timeout_cnt_o (tcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 unit after the next rising edge
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    m_cyc   = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0;
    s_dat_i = '0; s_ack = 1'b0;
    nxt(); nxt();
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_scyc", s_cyc, 1'b0);
    chk("rst_ack", m_ack, 2'b00);
    chk("rst_mdat", m_dat_o, 8'h00);
    chk("rst_tcnt", tcnt, 8'h00);
    rst_n = 1'b1;

    // Contention right after reset: m0 first, then m1
    nxt();
    m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b00;
    m_adr = {16'h2000, 16'h1000};
    #1;
    chk("ct_grant_lat", grant, 2'b00);
    nxt();
    s_ack = 1'b1; s_dat_i = 8'h33;
    #1;
    chk("ct_grant_m0", grant, 2'b01);
    chk("ct_sadr_m0", s_adr, 16'h1000);
    chk("ct_ack_m0", m_ack, 2'b01);
    chk("ct_rdat_m0", m_dat_o, 8'h33);
    nxt();
    m_cyc = 2'b10; m_stb = 2'b10; s_ack = 1'b0;
    #1;
    chk("ct_drop_scyc", s_cyc, 1'b0);
    chk("ct_drop_ack", m_ack, 2'b00);
    nxt();
    #1;
    chk("ct_idle_gap", grant, 2'b00);
    nxt();
    s_ack = 1'b1; s_dat_i = 8'h44;
    #1;
    chk("ct_grant_m1", grant, 2'b10);
    chk("ct_sadr_m1", s_adr, 16'h2000);
    chk("ct_ack_m1", m_ack, 2'b10);
    nxt();
    m_cyc = 2'b00; m_stb = 2'b00; s_ack = 1'b0;
    nxt();

    // Single master write, slave acks on the 3rd BUSY cycle
    m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b01;
    m_adr = {16'h0000, 16'h0102}; m_dat = {8'h00, 8'h5A};
    nxt();
    #1;
    chk("sm_grant", grant, 2'b01);
    chk("sm_scyc", s_cyc, 1'b1);
    chk("sm_sstb", s_stb, 1'b1);
    chk("sm_swe", s_we, 1'b1);
    chk("sm_sadr", s_adr, 16'h0102);
    chk("sm_sdat", s_dat_o, 8'h5A);
    chk("sm_noack1", m_ack, 2'b00);
    nxt();
    #1;
    chk("sm_noack2", m_ack, 2'b00);
    nxt();
    s_ack = 1'b1;
    #1;
    chk("sm_ack", m_ack, 2'b01);
    nxt();
    m_cyc = 2'b00; m_stb = 2'b00; m_we = 2'b00; s_ack = 1'b0;
    #1;
    chk("sm_ack_once", m_ack, 2'b00);
    nxt();

    // Burst: pointer now favours m1; m1 does 4 reads while m0 waits
    m_cyc = 2'b11; m_stb = 2'b11;
    m_adr = {16'h3000, 16'h4000};
    nxt();
    for (int k = 0; k < 4; k++) begin
      m_adr[31:16] = 16'h3000 + 16'(k);
      s_ack = 1'b1; s_dat_i = 8'h10 + 8'(k);
      #1;
      chk("bu_grant", grant, 2'b10);
      chk("bu_sadr", s_adr, 16'h3000 + 16'(k));
      chk("bu_ack", m_ack, 2'b10);
      chk("bu_rdat", m_dat_o, 8'h10 + 8'(k));
      nxt();
    end
    m_cyc = 2'b01; m_stb = 2'b01; s_ack = 1'b0;
    #1;
    chk("bu_hold_grant", grant, 2'b10);
    nxt();
    #1;
    chk("bu_idle", grant, 2'b00);
    nxt();
    s_ack = 1'b1; s_dat_i = 8'h55;
    #1;
    chk("bu_m0_grant", grant, 2'b01);
    chk("bu_m0_ack", m_ack, 2'b01);
    nxt();
    m_cyc = 2'b00; m_stb = 2'b00; s_ack = 1'b0;
    nxt();

    // Timeout: slave never answers m0 read
    m_cyc = 2'b01; m_stb = 2'b01; m_adr = {16'h0000, 16'h5000};
    nxt();
    for (int i = 0; i < 7; i++) begin
      #1;
      chk("to_wait_scyc", s_cyc, 1'b1);
      chk("to_wait_ack", m_ack, 2'b00);
      nxt();
    end
    s_ack = 1'b1; s_dat_i = 8'h77;
    #1;
    chk("to_scyc", s_cyc, 1'b0);
    chk("to_sstb", s_stb, 1'b0);
    chk("to_ack", m_ack, 2'b01);
    chk("to_rdat", m_dat_o, 8'hFF);
    chk("to_cnt", tcnt, 8'd1);
    nxt();
    m_cyc = 2'b00; m_stb = 2'b00; s_ack = 1'b0; s_dat_i = 8'h00;
    #1;
    chk("to_late_ack", m_ack, 2'b00);
    chk("to_cnt_hold", tcnt, 8'd1);
    nxt();

    // Ack lands exactly on the watchdog expiry cycle
    m_cyc = 2'b01; m_stb = 2'b01; m_adr = {16'h0000, 16'h6000};
    nxt();
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("co_wait_ack", m_ack, 2'b00);
      nxt();
    end
    s_ack = 1'b1; s_dat_i = 8'h99;
    #1;
    chk("co_ack", m_ack, 2'b01);
    chk("co_rdat", m_dat_o, 8'h99);
    nxt();
    m_cyc = 2'b00; m_stb = 2'b00; s_ack = 1'b0; s_dat_i = 8'h00;
    #1;
    chk("co_no_term_ack", m_ack, 2'b00);
    chk("co_no_term_dat", m_dat_o, 8'h00);
    chk("co_cnt", tcnt, 8'd1);
    nxt();

    // Async reset in the middle of an m1 burst
    m_cyc = 2'b10; m_stb = 2'b10; m_we = 2'b10; m_adr = {16'h7000, 16'h0000};
    m_dat = {8'hA5, 8'h00};
    nxt();
    s_ack = 1'b1; s_dat_i = 8'h21;
    #1;
    chk("ar_pre_grant", grant, 2'b10);
    nxt();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_grant", grant, 2'b00);
    chk("ar_scyc", s_cyc, 1'b0);
    chk("ar_sstb", s_stb, 1'b0);
    chk("ar_swe", s_we, 1'b0);
    chk("ar_sadr", s_adr, 16'h0000);
    chk("ar_sdat", s_dat_o, 8'h00);
    chk("ar_ack", m_ack, 2'b00);
    chk("ar_mdat", m_dat_o, 8'h00);
    chk("ar_tcnt", tcnt, 8'h00);
    nxt();
    s_ack = 1'b0; m_cyc = 2'b11; m_stb = 2'b11; m_we = 2'b00;
    m_adr = {16'h8001, 16'h8000};
    rst_n = 1'b1;
    #1;
    chk("ar_rel_grant", grant, 2'b00);
    nxt();
    #1;
    chk("ar_restart_m0", grant, 2'b01);
    chk("ar_restart_adr", s_adr, 16'h8000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
